// File: rtl/mips_membus_ctrl.sv
// Memory-bus sequencer for the multicycle MIPS core: serves fetch, load and store
// over a valid/ready bus of any width, with wait-state timeout and error reporting.
module mips_membus_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req,
    input  logic [1:0]         core_op,
    input  logic [ADDR_W-1:0]  core_adr,
    input  logic [DATA_W-1:0]  core_wdata,
    output logic               core_ready,
    output logic               core_done,
    output logic               core_err,
    output logic [INSTR_W-1:0] core_instr,
    output logic [DATA_W-1:0]  core_rdata,
    output logic               mem_valid,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ready,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int BEATS  = INSTR_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          op_r;
    logic [ADDR_W-1:0]   adr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [WAIT_W-1:0]   wait_r;
    logic [INSTR_W-1:0]  shadow_r;
    logic                err_r;
    logic [INSTR_W-1:0]  instr_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                hs_s;
    logic                last_s;
    logic                tmo_s;

    // Beat handshake, last-beat and timeout qualifiers; a handshake beats a timeout in the same cycle.
    always_comb begin
        hs_s   = 1'b0;
        last_s = 1'b0;
        tmo_s  = 1'b0;
        if (state_r == BUS) begin
            hs_s   = mem_ready;
            last_s = (op_r != OP_FETCH) || (32'(beat_r) == (BEATS - 1));
            tmo_s  = (TIMEOUT != 0) && !mem_ready &&
                     ((32'(wait_r) + 32'd1) == 32'(TIMEOUT));
        end else begin
            hs_s   = 1'b0;
            last_s = 1'b0;
            tmo_s  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (core_req) begin
                    state_s = (core_op == OP_RSVD) ? DONE : BUS;
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                if (hs_s && last_s) begin
                    state_s = DONE;
                end else if (tmo_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUS;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latch, beat/wait counters, shadow capture and result commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 2'b00;
            adr_r    <= '0;
            wdata_r  <= '0;
            beat_r   <= '0;
            wait_r   <= '0;
            shadow_r <= '0;
            err_r    <= 1'b0;
            instr_r  <= '0;
            rdata_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (core_req) begin
                        op_r    <= core_op;
                        adr_r   <= core_adr;
                        wdata_r <= core_wdata;
                        err_r   <= (core_op == OP_RSVD);
                        beat_r  <= '0;
                        wait_r  <= '0;
                    end
                end
                BUS: begin
                    if (hs_s) begin
                        if (op_r == OP_FETCH) begin
                            shadow_r[32'(beat_r) * DATA_W +: DATA_W] <= mem_rdata;
                        end else begin
                            shadow_r[DATA_W-1:0] <= mem_rdata;
                        end
                        beat_r <= beat_r + BEAT_W'(1);
                        wait_r <= '0;
                    end else begin
                        wait_r <= wait_r + WAIT_W'(1);
                        if (tmo_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Aborted transfers leave the architectural results untouched.
                    if (!err_r) begin
                        if (op_r == OP_FETCH) begin
                            instr_r <= shadow_r;
                        end else if (op_r == OP_LOAD) begin
                            rdata_r <= shadow_r[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                    beat_r <= '0;
                    wait_r <= '0;
                end
            endcase
        end
    end

    assign core_ready = (state_r == IDLE);
    assign core_done  = (state_r == DONE);
    assign core_err   = (state_r == DONE) && err_r;
    assign core_instr = instr_r;
    assign core_rdata = rdata_r;
    assign mem_valid  = (state_r == BUS);
    assign mem_we     = (state_r == BUS) && (op_r == OP_STORE);
    assign mem_adr    = (state_r == BUS) ? (adr_r + ADDR_W'(beat_r)) : '0;
    assign mem_wdata  = (state_r == BUS) ? wdata_r : '0;

endmodule

// File: tb/tb_mips_membus_ctrl.sv
// Randomized scoreboard bench for mips_membus_ctrl: a memory responder and a done
// monitor check the DUT against a transaction-level reference model.
module tb_mips_membus_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 32;
    localparam int TIMEOUT = 4;
    localparam int BEATS   = INSTR_W / DATA_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               core_req;
    logic [1:0]         core_op;
    logic [ADDR_W-1:0]  core_adr;
    logic [DATA_W-1:0]  core_wdata;
    logic               core_ready;
    logic               core_done;
    logic               core_err;
    logic [INSTR_W-1:0] core_instr;
    logic [DATA_W-1:0]  core_rdata;
    logic               mem_valid;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_adr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_rdata;

    mips_membus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_op(core_op), .core_adr(core_adr), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_done(core_done), .core_err(core_err),
        .core_instr(core_instr), .core_rdata(core_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] adr;
        logic       we;
        logic [7:0] wdata;
        int         w;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] instr;
        logic [7:0]  rdata;
    } exp_t;

    beat_t       beat_q[$];
    exp_t        exp_q[$];
    logic [7:0]  bus_mem[256];
    logic [7:0]  ref_mem[256];
    logic [31:0] cur_instr;
    logic [7:0]  cur_rdata;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int rw();
        return ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
    endfunction

    // Memory responder: checks each beat's address/strobe/data, inserts wait states.
    initial begin
        beat_t cur;
        bit    have;
        int    stall;
        have  = 1'b0;
        stall = 0;
        forever begin
            @(negedge clk);
            mem_rdata = 8'($urandom);
            if (reset) begin
                have      = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                if (!have && beat_q.size() == 0) begin
                    check("bus_unexpected_beat", 64'd1, 64'd0);
                    mem_ready = 1'b0;
                end else begin
                    if (!have) begin
                        cur   = beat_q.pop_front();
                        have  = 1'b1;
                        stall = cur.w;
                    end
                    check("mem_adr", 64'(mem_adr), 64'(cur.adr));
                    check("mem_we", 64'(mem_we), 64'(cur.we));
                    check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    if (stall > 0) begin
                        mem_ready = 1'b0;
                        stall--;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = bus_mem[cur.adr];
                        if (cur.we) bus_mem[cur.adr] = mem_wdata;
                        have = 1'b0;
                    end
                end
            end else begin
                mem_ready = 1'b0;
                if (have) begin
                    have = 1'b0;
                    check("bus_dropped_early", 64'(cur.w >= TIMEOUT), 64'd1);
                end
            end
        end
    end

    // Completion monitor: pops the expected result on each done pulse.
    initial begin
        exp_t e;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            check("err_without_done", 64'(core_err & ~core_done), 64'd0);
            if (pend) begin
                check("core_instr", 64'(core_instr), 64'(e.instr));
                check("core_rdata", 64'(core_rdata), 64'(e.rdata));
                check("ready_after_done", 64'(core_ready), 64'd1);
                check("done_single_cycle", 64'(core_done), 64'd0);
                pend = 1'b0;
            end else if (core_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("core_err", 64'(core_err), 64'(e.err));
                    pend = 1'b1;
                end
            end
        end
    end

    // Model one transaction, issue it, and check its completion latency.
    task automatic run(input logic [1:0] op, input logic [7:0] adr, input logic [7:0] wd,
                       input int w0, input int w1, input int w2, input int w3);
        int          ws[4];
        int          nb;
        int          lat;
        int          cyc;
        int          n;
        logic        err;
        logic [7:0]  a;
        logic [31:0] new_instr;
        logic [7:0]  new_rdata;
        beat_t       b;
        exp_t        e;
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        err = (op == 2'b11);
        lat = 1;
        new_instr = 32'd0;
        new_rdata = 8'd0;
        nb = (op == 2'b00) ? BEATS : ((op == 2'b11) ? 0 : 1);
        for (int k = 0; k < nb && !err; k++) begin
            a       = adr + 8'(k);
            b.adr   = a;
            b.we    = (op == 2'b10);
            b.wdata = wd;
            b.w     = ws[k];
            beat_q.push_back(b);
            if (ws[k] >= TIMEOUT) begin
                lat += TIMEOUT;
                err  = 1'b1;
            end else begin
                lat += ws[k] + 1;
                new_instr[k*8 +: 8] = ref_mem[a];
                new_rdata = ref_mem[a];
                if (op == 2'b10) ref_mem[a] = wd;
            end
        end
        if (!err && op == 2'b00) cur_instr = new_instr;
        if (!err && op == 2'b01) cur_rdata = new_rdata;
        e.err   = err;
        e.instr = cur_instr;
        e.rdata = cur_rdata;
        exp_q.push_back(e);

        n = 0;
        while (!core_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", 64'(core_ready), 64'd1);
        core_req   = 1'b1;
        core_op    = op;
        core_adr   = adr;
        core_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        core_req   = 1'b0;
        core_op    = 2'($urandom);
        core_adr   = 8'($urandom);
        core_wdata = 8'($urandom);
        cyc = 1;
        while (!core_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", 64'(cyc), 64'(lat));
    endtask

    initial begin
        int          n;
        beat_t       b;
        logic [1:0]  op;
        logic [31:0] sel;
        reset      = 1'b1;
        core_req   = 1'b0;
        core_op    = 2'b00;
        core_adr   = 8'd0;
        core_wdata = 8'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 8'd0;
        cur_instr  = 32'd0;
        cur_rdata  = 8'd0;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
        end
        bus_mem[8'h10] = 8'h20; bus_mem[8'h11] = 8'h03;
        bus_mem[8'h12] = 8'h02; bus_mem[8'h13] = 8'h8C;
        bus_mem[8'h40] = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = bus_mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_ready", 64'(core_ready), 64'd1);
        check("rst_core_done", 64'(core_done), 64'd0);
        check("rst_core_err", 64'(core_err), 64'd0);
        check("rst_core_instr", 64'(core_instr), 64'd0);
        check("rst_core_rdata", 64'(core_rdata), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_adr", 64'(mem_adr), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run(2'b00, 8'h10, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        check("fetch_0x10_instr", 64'(core_instr), 64'h8C020320);
        run(2'b01, 8'h40, 8'h00, 3, 0, 0, 0);
        @(negedge clk);
        check("load_0x40_rdata", 64'(core_rdata), 64'hA5);
        run(2'b10, 8'hFF, 8'h3C, 0, 0, 0, 0);
        run(2'b00, 8'hFF, 8'h00, 0, 1, 0, 2);
        run(2'b00, 8'h20, 8'h00, 4, 0, 0, 0);
        run(2'b00, 8'h30, 8'h00, 0, 5, 0, 0);
        run(2'b01, 8'h50, 8'h00, 3, 0, 0, 0);
        run(2'b11, 8'h60, 8'h00, 0, 0, 0, 0);

        // Reset in the middle of a fetch: no done, bus released, results cleared.
        for (int k = 0; k < BEATS; k++) begin
            b.adr = 8'h80 + 8'(k); b.we = 1'b0; b.wdata = 8'h00; b.w = 0;
            beat_q.push_back(b);
        end
        n = 0;
        while (!core_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        core_req = 1'b1; core_op = 2'b00; core_adr = 8'h80; core_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        core_req = 1'b0;
        @(negedge clk);
        check("rst_test_mid_valid", 64'(mem_valid), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mid_core_ready", 64'(core_ready), 64'd1);
        check("rst_mid_core_done", 64'(core_done), 64'd0);
        check("rst_mid_core_instr", 64'(core_instr), 64'd0);
        beat_q.delete();
        cur_instr = 32'd0;
        cur_rdata = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(2'b00, 8'h10, 8'h00, 1, 0, 2, 0);

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? 2'b00 : ((sel < 7) ? 2'b01 : ((sel < 9) ? 2'b10 : 2'b11));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(op, 8'($urandom), 8'($urandom), rw(), rw(), rw(), rw());
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("beat_q_drained", 64'(beat_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_membus_ctrl.md
Name: mips_membus_ctrl

Overview:
- Parametrised memory-bus sequencer for the multicycle MIPS core.
- Generalises the fixed four-cycle byte-serial instruction fetch to any bus width.
- Adds a valid/ready handshake so memory may insert wait states, and a timeout that reports an error.
- Sits between the core controller/datapath and the external memory port; serves instruction fetch, load and store.

Parameters:
- ADDR_W, 8, address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory data bus width.
- INSTR_W, 32, instruction width; must be an integer multiple of DATA_W. BEATS = INSTR_W/DATA_W.
- TIMEOUT, 16, consecutive stalled cycles before a request aborts; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- core_req  in  1  request; sampled only while core_ready=1.
- core_op  in  2  operation: 00 fetch, 01 load, 10 store, 11 reserved.
- core_adr  in  ADDR_W  start address.
- core_wdata  in  DATA_W  store data.
- core_ready  out  1  block is idle and accepts a request.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  asserted with core_done on abort or reserved op.
- core_instr  out  INSTR_W  last successfully fetched instruction.
- core_rdata  out  DATA_W  last successfully loaded data.
- mem_valid  out  1  bus request active.
- mem_we  out  1  write strobe; qualified by mem_valid.
- mem_adr  out  ADDR_W  beat address.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  memory accepts or completes the current beat.
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1.

Behaviour:
- Reset values: state IDLE, core_ready=1. All other outputs 0. Beat counter, wait counter, core_instr, core_rdata and the shadow register all clear to 0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - core_req=1 at a clock edge latches op, adr and wdata.
  - op 00/01/10 goes to BUS.
  - op 11 goes to DONE with err flagged; no bus activity occurs.
- BUS:
  - mem_valid=1.
  - mem_adr = latched adr + beat (mod 2^ADDR_W).
  - mem_we=1 only for store; mem_wdata = latched wdata.
  - mem_adr, mem_we and mem_wdata are held stable while mem_ready=0.
- Handshake: a beat completes at a clock edge with mem_valid & mem_ready.
  - Fetch: beat k writes mem_rdata into shadow[k*DATA_W +: DATA_W]; beat 0 is the least significant.
  - Load: mem_rdata is captured into a shadow byte.
  - mem_valid stays high back-to-back across beats; the next beat address appears in the cycle after the handshake.
- Beat counts: fetch is BEATS beats; load and store are 1 beat each. After the last beat the FSM goes to DONE.
- Timeout:
  - The wait counter increments on every BUS cycle with mem_ready=0 and clears on each handshake.
  - When it reaches TIMEOUT (TIMEOUT≠0), the FSM goes to DONE with err; mem_valid drops in that same transition.
- DONE:
  - core_done=1 for exactly one cycle, then IDLE.
  - On success: fetch copies shadow to core_instr; load copies shadow to core_rdata, both in this cycle.
  - On err: core_instr and core_rdata are unchanged.
  - core_err=1 only on error.
- core_ready=1 only in IDLE; the core must not change request fields while core_ready=0 (they are ignored).
- Latency with mem_ready tied to 1:
  - Fetch: request at edge 0, BUS cycles 1..BEATS, done at cycle BEATS+1, ready at cycle BEATS+2.
  - Load/store: done at cycle 2.
- Reset during BUS: mem_valid=0 from the cycle after reset is sampled; partial fetch data is discarded and no done pulse is issued.
- Wrap-around: a fetch at adr = 2^ADDR_W-1 issues beats at adr, then 0, 1, ...
- A mem_ready that arrives in the same cycle the wait counter hits TIMEOUT counts as a handshake; timeout does not fire.

Test Plan:
- Defaults, mem_ready=1: fetch adr 0x10, memory bytes 0x10..0x13 = 0x20,0x03,0x02,0x8C -> mem_adr 10,11,12,13 in cycles 1-4; core_done in cycle 5; core_instr = 0x8C020320; core_err=0.
- Load adr 0x40 with 3 wait cycles, rdata 0xA5 -> mem_adr stays 0x40 for 4 cycles; core_rdata = 0xA5; done 1 cycle after the handshake.
- Store adr 0xFF data 0x3C -> single beat with mem_we=1, mem_adr=0xFF, mem_wdata=0x3C; core_done=1, core_err=0; core_rdata unchanged.
- Wrap-around, DATA_W=16, INSTR_W=32: fetch at 0xFF -> beats at 0xFF then 0x00; core_instr = {beat1, beat0}.
- Timeout, TIMEOUT=4, mem_ready=0: fetch -> mem_valid high for 4 cycles then low; core_done=core_err=1; core_instr keeps its previous value. Op 11 -> err pulse at cycle 1 with no mem_valid.
- Reset asserted at beat 2 of a fetch -> mem_valid=0 next cycle, core_ready=1, no core_done; a new fetch afterwards completes normally.
